// File: rtl/sext_accum.sv
// Frame accumulator: sums COUNT sign/zero-extended samples (or fewer on flush) and holds the
// result until the consumer accepts it. Define SEXT_ACCUM_SAT_EN for saturating adds.
module sext_accum #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [7:0]       out_cnt
);

    localparam logic [7:0] CountW = 8'(COUNT);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [7:0]       out_cnt_q, out_cnt_d;

    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] sum;
    logic [7:0]       cnt_inc;
    logic             accept;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;

    assign accept  = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        ext_data = '0;
        ext_data[IN_W-1:0] = in_data;
        for (int i = IN_W; i < OUT_W; i++) begin
            ext_data[i] = (SIGNED != 0) && in_data[IN_W-1];
        end
    end

`ifdef SEXT_ACCUM_SAT_EN
    logic [OUT_W:0] wide;

    always_comb begin
        wide = {1'b0, acc_q} + {1'b0, ext_data};
        sum  = wide[OUT_W-1:0];
        if (SIGNED != 0) begin
            // Overflow only when both operands share a sign the result lost.
            if ((acc_q[OUT_W-1] == ext_data[OUT_W-1]) && (wide[OUT_W-1] != acc_q[OUT_W-1])) begin
                sum = acc_q[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else if (wide[OUT_W]) begin
            sum = '1;
        end
    end
`else
    assign sum = acc_q + ext_data;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;

        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    acc_d   = sum;
                    cnt_d   = cnt_inc;
                    state_d = StAccum;
                    if ((cnt_inc == CountW) || flush) begin
                        state_d     = StHold;
                        out_valid_d = 1'b1;
                        out_data_d  = sum;
                        out_cnt_d   = cnt_inc;
                    end
                end else if (flush && (state_q == StAccum)) begin
                    state_d     = StHold;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_cnt_d   = cnt_q;
                end
            end
            StHold: begin
                if (out_valid_q && out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so in_ready rises one cycle after reset release or result handoff.
        in_ready_d = (state_d != StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_sext_accum.sv
// Directed table-driven bench for sext_accum: four instances (signed/unsigned x COUNT 4/32)
// sharing stimulus, with in_valid/flush routed only to the selected instance.
module tb_sext_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, flush, out_ready;
    logic [3:0] in_data;
    int         sel;

    logic       ov [4];
    logic       ir [4];
    logic [7:0] od [4];
    logic [7:0] oc [4];
    logic       ov_m, ir_m;
    logic [7:0] od_m, oc_m;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] samples [32];

    always #5 clk = ~clk;

    always_comb begin
        ov_m = ov[sel];
        ir_m = ir[sel];
        od_m = od[sel];
        oc_m = oc[sel];
    end

    sext_accum #(.IN_W(4), .OUT_W(8), .SIGNED(1), .COUNT(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
        .in_data(in_data), .flush(flush && sel == 0), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_cnt(oc[0]));
    sext_accum #(.IN_W(4), .OUT_W(8), .SIGNED(0), .COUNT(4)) u_u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
        .in_data(in_data), .flush(flush && sel == 1), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_cnt(oc[1]));
    sext_accum #(.IN_W(4), .OUT_W(8), .SIGNED(1), .COUNT(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
        .in_data(in_data), .flush(flush && sel == 2), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_cnt(oc[2]));
    sext_accum #(.IN_W(4), .OUT_W(8), .SIGNED(0), .COUNT(32)) u_u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(ir[3]),
        .in_data(in_data), .flush(flush && sel == 3), .out_valid(ov[3]), .out_ready(out_ready),
        .out_data(od[3]), .out_cnt(oc[3]));

    typedef struct {
        int         sel;
        logic [3:0] val;
        int         n;
        bit         fl;
        logic [7:0] ed;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Feeds samples[0..n-1], checks latency-1 result, hold stability and the handoff.
    task automatic run_frame(input int s, input int n, input bit fl, input logic [7:0] ed,
                             input logic [7:0] ec, input string tag);
        bit hold_ok;
        sel = s;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, " ready at start"}, 32'(ir_m), 32'd1);
            if (i == n - 1) chk({tag, " valid early"}, 32'(ov_m), 32'd0);
            in_valid = 1'b1;
            in_data  = samples[i];
            flush    = fl && (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk({tag, " valid latency"}, 32'(ov_m), 32'd1);
        chk({tag, " data"}, 32'(od_m), 32'(ed));
        chk({tag, " cnt"}, 32'(oc_m), 32'(ec));
        chk({tag, " ready in hold"}, 32'(ir_m), 32'd0);
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 4'h3;
            flush    = 1'b1;
            @(negedge clk);
            if (!(ov_m === 1'b1 && od_m === ed && oc_m === ec && ir_m === 1'b0)) hold_ok = 1'b0;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        chk({tag, " hold stable"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid after handoff"}, 32'(ov_m), 32'd0);
        chk({tag, " ready after handoff"}, 32'(ir_m), 32'd1);
        chk({tag, " data kept"}, 32'(od_m), 32'(ed));
    endtask

    initial begin
        vecs[0] = '{0, 4'hD, 4,  1'b0, 8'hF4, 8'd4};
        vecs[1] = '{1, 4'hD, 4,  1'b0, 8'h34, 8'd4};
        vecs[2] = '{0, 4'hD, 2,  1'b1, 8'hFA, 8'd2};
        vecs[3] = '{0, 4'h5, 1,  1'b1, 8'h05, 8'd1};
        vecs[4] = '{1, 4'hF, 3,  1'b1, 8'h2D, 8'd3};
        vecs[5] = '{0, 4'h7, 4,  1'b0, 8'h1C, 8'd4};
`ifdef SEXT_ACCUM_SAT_EN
        vecs[6] = '{2, 4'h8, 32, 1'b0, 8'h80, 8'd32};
        vecs[7] = '{3, 4'hF, 32, 1'b0, 8'hFF, 8'd32};
        vecs[8] = '{2, 4'h7, 32, 1'b0, 8'h7F, 8'd32};
`else
        vecs[6] = '{2, 4'h8, 32, 1'b0, 8'h00, 8'd32};
        vecs[7] = '{3, 4'hF, 32, 1'b0, 8'hE0, 8'd32};
        vecs[8] = '{2, 4'h7, 32, 1'b0, 8'hE0, 8'd32};
`endif
        vecs[9] = '{3, 4'h1, 5,  1'b1, 8'h05, 8'd5};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 4'h0;
        sel = 0;
        #1;
        chk("reset valid", 32'(ov_m), 32'd0);
        chk("reset ready", 32'(ir_m), 32'd0);
        chk("reset data", 32'(od_m), 32'd0);
        chk("reset cnt", 32'(oc_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready before first edge", 32'(ir_m), 32'd0);
        @(negedge clk);
        chk("ready after first edge", 32'(ir_m), 32'd1);

        // Flush in IDLE with no sample must be ignored.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("idle flush valid", 32'(ov_m), 32'd0);
        @(negedge clk);
        chk("idle flush valid later", 32'(ov_m), 32'd0);
        chk("idle flush ready", 32'(ir_m), 32'd1);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vecs[v].n; i++) samples[i] = vecs[v].val;
            run_frame(vecs[v].sel, vecs[v].n, vecs[v].fl, vecs[v].ed, vecs[v].ec,
                      $sformatf("vec%0d", v));
        end

        samples[0] = 4'h8; samples[1] = 4'h7; samples[2] = 4'hF; samples[3] = 4'h1;
        run_frame(0, 4, 1'b0, 8'hFF, 8'd4, "mixed");

        // Reset after 2 of 4 samples discards the partial frame.
        sel = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'h3;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset valid", 32'(ov_m), 32'd0);
        chk("midreset ready", 32'(ir_m), 32'd0);
        chk("midreset data", 32'(od_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit quiet = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (ov_m !== 1'b0) quiet = 1'b0;
            end
            chk("midreset no valid", 32'(quiet), 32'd1);
        end
        for (int i = 0; i < 4; i++) samples[i] = 4'h1;
        run_frame(0, 4, 1'b0, 8'h04, 8'd4, "post-reset");

        // Reset while a result is pending drops it at once.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'h2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pending valid", 32'(ov_m), 32'd1);
        chk("pending data", 32'(od_m), 32'h08);
        rst_n = 1'b0;
        #1;
        chk("hold reset valid", 32'(ov_m), 32'd0);
        chk("hold reset data", 32'(od_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 4, 1'b0, 8'h04, 8'd4, "post-hold-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sext_accum.md
SEXT_ACCUM -- requirements
Module: sext_accum

Interface
REQ-001 Parameter IN_W, default 4: input sample width in bits, at least 2.
REQ-002 Parameter OUT_W, default 8: accumulator and output width in bits, at least IN_W.
REQ-003 Parameter SIGNED, default 1: 1 sign-extends in_data to OUT_W; 0 zero-extends it.
REQ-004 Parameter COUNT, default 4: samples per frame, range 2..255.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  IN_W  sample, interpreted according to SIGNED.
REQ-010 flush  input  1  closes the current frame early.
REQ-011 out_valid  output  1  out_data and out_cnt are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  OUT_W  accumulated frame sum.
REQ-014 out_cnt  output  8  number of samples summed into out_data.

Function
REQ-015 States SHALL be IDLE (cnt=0), ACCUM (0<cnt<COUNT) and HOLD (result pending).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 Accept SHALL mean in_valid&&in_ready; on accept: acc <= acc + ext(in_data); cnt <= cnt+1.
REQ-018 ext() SHALL replicate bit IN_W-1 when SIGNED=1 and pad zeros when SIGNED=0.
REQ-019 Accept taking cnt to COUNT SHALL load out_data<=next acc and out_cnt<=COUNT, assert out_valid on the next cycle (latency 1), and enter HOLD.
REQ-020 flush in ACCUM SHALL enter HOLD with out_cnt=cnt; if an accept occurs the same cycle, that sample SHALL be included and counted.
REQ-021 flush in IDLE with an accept SHALL produce a 1-sample frame; flush in IDLE without an accept SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-022 In HOLD, out_data, out_cnt and out_valid SHALL stay stable until out_valid&&out_ready.
REQ-023 On out_valid&&out_ready: out_valid<=0, acc<=0, cnt<=0, state<=IDLE; in_ready SHALL rise the following cycle, not the same cycle.
REQ-024 Arithmetic without the Configuration macro SHALL wrap modulo 2^OUT_W.
REQ-025 out_data SHALL be unchanged while out_valid is 0.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_cnt=0 and in_ready=0.
REQ-027 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-frame or in HOLD SHALL discard partial and pending results without any out_valid pulse.

Configuration
REQ-029 Macro SEXT_ACCUM_SAT_EN defined: each add SHALL saturate.
  - SIGNED=1 range: -2^(OUT_W-1) .. 2^(OUT_W-1)-1.
  - SIGNED=0 range: 0 .. 2^OUT_W-1.
  - Undefined: wrap per REQ-024, with no saturation logic present.

Verification (IN_W=4, OUT_W=8 unless stated)
REQ-030 SIGNED=1, COUNT=4, in_data=4'hD x4 -> out_data=8'hF4, out_cnt=4, out_valid exactly 1 cycle after the 4th accept.
REQ-031 SIGNED=0, COUNT=4, in_data=4'hD x4 -> out_data=8'h34.
REQ-032 COUNT=32 overflow cases:
  - SIGNED=1, 4'h8 x32 -> 8'h00 without macro; 8'h80 with macro.
  - SIGNED=0, 4'hF x32 -> 8'hE0 without macro; 8'hFF with macro.
REQ-033 SIGNED=1, COUNT=4: 4'hD, then 4'hD with flush in the same cycle -> out_data=8'hFA, out_cnt=2.
REQ-034 Result pending with out_ready=0 for 5 cycles -> out_data stable and in_ready=0 throughout; out_ready=1 -> out_valid drops, in_ready rises the next cycle.
REQ-035 rst_n pulsed low after 2 of 4 samples -> no out_valid; a following full frame of 4'h1 x4 -> 8'h04.
